// File: rtl/posit8_pkg.sv
// Shared posit8 (es=0) constants and the decoded-field record passed between
// the field-extract stage and the fixed-point assembler.
package posit8_pkg;

  localparam logic [7:0] POSIT8_NAR       = 8'h80;
  localparam logic [7:0] POSIT8_ZERO      = 8'h00;
  localparam int         POSIT8_MAXK      = 6;
  localparam int         POSIT8_FRAC_BITS = 5;

  typedef struct packed {
    logic                        sign;
    logic signed [3:0]           k;
    logic [POSIT8_FRAC_BITS-1:0] frac;
    logic                        zero;
    logic                        nar;
  } posit8_fields_t;

endpackage

// File: rtl/posit8_field_extract.sv
// Combinational posit8 (es=0) decode: magnitude, regime value k and the
// left-aligned 5-bit fraction.
module posit8_field_extract
  import posit8_pkg::*;
(
  input  logic [7:0]     posit,
  output posit8_fields_t fields
);

  logic [7:0]  mag_s;
  logic        lead_s;
  logic        stop_s;
  logic [3:0]  run_s;
  logic [11:0] shifted_s;

  // Count the regime run, then shift regime and terminator out so the fraction lands at the top.
  always_comb begin
    mag_s  = posit[7] ? (8'd0 - posit) : posit;
    lead_s = mag_s[6];
    run_s  = 4'd0;
    stop_s = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!stop_s && (mag_s[i] == lead_s)) begin
        run_s = run_s + 4'd1;
      end else begin
        stop_s = 1'b1;
      end
    end
    shifted_s   = {mag_s[6:0], 5'b00000} << (run_s + 4'd1);
    fields.sign = posit[7];
    fields.k    = lead_s ? $signed(run_s - 4'd1) : $signed(4'd0 - run_s);
    fields.frac = shifted_s[11:7];
    fields.zero = (posit == POSIT8_ZERO);
    fields.nar  = (posit == POSIT8_NAR);
  end

endmodule

// File: rtl/posit8_to_fixed_stream.sv
// Two-stage valid/ready converter from posit8 (es=0) to signed Q(OUT_W-FRAC_W).FRAC_W,
// with a NaR sideband flag and a saturating NaR counter.
module posit8_to_fixed_stream
  import posit8_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_posit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_nar,
  input  logic             cnt_clr,
  output logic [7:0]       nar_count
);

  // {1,f5} carries 5 fraction bits and k is offset by MAXK, so this right shift rescales to FRAC_W.
  localparam int ALIGN_SHR = POSIT8_FRAC_BITS + POSIT8_MAXK - FRAC_W;

  posit8_fields_t   ext_s;
  posit8_fields_t   s1_fields_r;
  logic             s1_valid_r;
  logic             out_valid_r;
  logic             out_nar_r;
  logic [OUT_W-1:0] out_data_r;
  logic [OUT_W-1:0] asm_data_s;
  logic [OUT_W-1:0] mag_s;
  logic [7:0]       nar_count_r;
  logic [3:0]       shamt_s;
  logic [17:0]      scaled_s;
  logic             s2_load_s;
  logic             s1_adv_s;
  logic             accept_s;

  assign s2_load_s = ~out_valid_r | out_ready;
  assign s1_adv_s  = ~s1_valid_r | s2_load_s;
  assign in_ready  = ~rst & s1_adv_s;
  assign accept_s  = in_valid & in_ready;

  posit8_field_extract u_extract (
    .posit  (in_posit),
    .fields (ext_s)
  );

  // Stage-2 assembly: exact magnitude from {1,f5} and k, then sign / zero / NaR override.
  always_comb begin
    shamt_s  = 4'(s1_fields_r.k) + 4'(POSIT8_MAXK);
    scaled_s = 18'({1'b1, s1_fields_r.frac}) << shamt_s;
    mag_s    = OUT_W'(scaled_s >> ALIGN_SHR);
    if (s1_fields_r.nar) begin
      asm_data_s = {1'b1, {(OUT_W-1){1'b0}}};
    end else if (s1_fields_r.zero) begin
      asm_data_s = {OUT_W{1'b0}};
    end else if (s1_fields_r.sign) begin
      asm_data_s = {OUT_W{1'b0}} - mag_s;
    end else begin
      asm_data_s = mag_s;
    end
  end

  // Stage-1 register: decoded fields of the accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_fields_r <= '{sign: 1'b0, k: 4'sd0, frac: 5'd0, zero: 1'b0, nar: 1'b0};
    end else if (s1_adv_s) begin
      s1_valid_r  <= in_valid;
      s1_fields_r <= ext_s;
    end
  end

  // Output register: data/nar only change when a new word moves in, so they hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      out_nar_r   <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= asm_data_s;
        out_nar_r  <= s1_fields_r.nar;
      end
    end
  end

  // Saturating NaR counter; clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      nar_count_r <= 8'd0;
    end else if (cnt_clr) begin
      nar_count_r <= 8'd0;
    end else if (accept_s && (in_posit == POSIT8_NAR) && (nar_count_r != 8'hFF)) begin
      nar_count_r <= nar_count_r + 8'd1;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_nar   = out_nar_r;
  assign nar_count = nar_count_r;

endmodule

// File: tb/tb_posit8_to_fixed_stream.sv
// Self-checking bench for posit8_to_fixed_stream: directed vectors, NaR counting,
// backpressure, a randomized exhaustive stream and mid-stream reset.
module tb_posit8_to_fixed_stream;

  localparam int OUT_W  = 16;
  localparam int FRAC_W = 8;

  if ((FRAC_W < 6) || (FRAC_W > 8) || (OUT_W - FRAC_W < 8)) begin : g_param_check
    $error("illegal OUT_W/FRAC_W combination");
  end

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_posit;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_nar;
  logic             cnt_clr;
  logic [7:0]       nar_count;

  int tests_run;
  int tests_failed;

  posit8_to_fixed_stream #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nar   (out_nar),
    .cnt_clr   (cnt_clr),
    .nar_count (nar_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: value = (-1)^s * 2^k * (1 + frac/2^nf), scaled by 2^FRAC_W.
  function automatic logic [OUT_W-1:0] ref_fixed(input logic [7:0] p);
    int m, first, run, i, k, nf, frac, e, r;
    if (p == 8'h00) return {OUT_W{1'b0}};
    if (p == 8'h80) return {1'b1, {(OUT_W-1){1'b0}}};
    m     = p[7] ? (256 - int'(p)) : int'(p);
    first = (m >> 6) & 1;
    run   = 0;
    i     = 6;
    while ((i >= 0) && (((m >> i) & 1) == first)) begin
      run++;
      i--;
    end
    k    = (first == 1) ? run - 1 : -run;
    nf   = (i > 0) ? i : 0;
    frac = m & ((1 << nf) - 1);
    e    = k + FRAC_W - nf;
    r    = (e >= 0) ? (((1 << nf) + frac) << e) : (((1 << nf) + frac) >> (-e));
    if (p[7]) r = -r;
    return OUT_W'(r);
  endfunction

  // Samples one cycle mid-period, then advances past the next rising edge.
  task automatic tick(output bit in_fire, output bit ov, output logic [OUT_W-1:0] d, output bit n);
    #2;
    in_fire = in_valid && in_ready;
    ov      = out_valid;
    d       = out_data;
    n       = out_nar;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_posit = 8'h00;
    @(posedge clk);
    #2;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    tests_run++;
    if (out_nar !== 1'b0) begin tests_failed++; $display("FAIL reset_out_nar: got %b expected 0", out_nar); end
    tests_run++;
    if (nar_count !== 8'd0) begin tests_failed++; $display("FAIL reset_nar_count: got %0d expected 0", nar_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0]       pin [7];
    logic [OUT_W-1:0] exp [7];
    bit               inf, ov, n;
    logic [OUT_W-1:0] d;
    pin = '{8'h40, 8'h50, 8'h60, 8'h7F, 8'h01, 8'hC0, 8'h00};
    exp = '{16'h0100, 16'h0180, 16'h0200, 16'h4000, 16'h0004, 16'hFF00, 16'h0000};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_posit = pin[i];
      in_valid = 1'b1;
      tick(inf, ov, d, n);
      in_valid = 1'b0;
      tests_run++;
      if (!inf) begin tests_failed++; $display("FAIL single_accept[%h]: got 0 expected 1", pin[i]); end
      tick(inf, ov, d, n);
      tests_run++;
      if (ov) begin tests_failed++; $display("FAIL single_early[%h]: out_valid got 1 expected 0", pin[i]); end
      tick(inf, ov, d, n);
      tests_run++;
      if (!ov || d !== exp[i] || n !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_data[%h]: got v=%b d=%h nar=%b expected v=1 d=%h nar=0", pin[i], ov, d, n, exp[i]);
      end
    end
  endtask

  task automatic test_nar();
    bit               inf, ov, n;
    logic [OUT_W-1:0] d;
    int               acc, cyc;
    out_ready = 1'b1;
    in_posit  = 8'h80;
    in_valid  = 1'b1;
    tick(inf, ov, d, n);
    in_valid = 1'b0;
    tests_run++;
    if (nar_count !== 8'd1) begin tests_failed++; $display("FAIL nar_count_one: got %0d expected 1", nar_count); end
    tick(inf, ov, d, n);
    tick(inf, ov, d, n);
    tests_run++;
    if (!ov || d !== 16'h8000 || n !== 1'b1) begin
      tests_failed++;
      $display("FAIL nar_data: got v=%b d=%h nar=%b expected v=1 d=8000 nar=1", ov, d, n);
    end
    acc = 0; cyc = 0;
    in_valid = 1'b1;
    while (acc < 300 && cyc < 1000) begin
      tick(inf, ov, d, n);
      if (inf) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc != 300) begin tests_failed++; $display("FAIL nar_stream_accepts: got %0d expected 300", acc); end
    tests_run++;
    if (nar_count !== 8'd255) begin tests_failed++; $display("FAIL nar_saturate: got %0d expected 255", nar_count); end
    cnt_clr  = 1'b1;
    in_valid = 1'b1;
    tick(inf, ov, d, n);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (!inf || nar_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL nar_clear_wins: got accept=%b count=%0d expected accept=1 count=0", inf, nar_count);
    end
    repeat (3) tick(inf, ov, d, n);
  endtask

  task automatic test_back_to_back();
    logic [7:0]       pin [4];
    logic [OUT_W-1:0] exp [4];
    bit               inf, ov, n;
    logic [OUT_W-1:0] d;
    int               idx, got, last, cyc;
    pin = '{8'h40, 8'h50, 8'h60, 8'h7F};
    exp = '{16'h0100, 16'h0180, 16'h0200, 16'h4000};
    idx = 0;
    out_ready = 1'b0;
    in_posit  = pin[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(inf, ov, d, n);
      if (inf) begin
        idx++;
        if (idx < 4) in_posit = pin[idx];
        else in_valid = 1'b0;
      end
      if (c >= 2) begin
        tests_run++;
        if (!ov || d !== 16'h0100) begin
          tests_failed++;
          $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=0100", c, ov, d);
        end
      end
    end
    tests_run++;
    if (idx != 2) begin tests_failed++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    got = 0; last = -1; cyc = 0;
    while (got < 4 && cyc < 20) begin
      tick(inf, ov, d, n);
      if (inf) begin
        idx++;
        if (idx < 4) in_posit = pin[idx];
        else in_valid = 1'b0;
      end
      if (ov) begin
        tests_run++;
        if (d !== exp[got] || (last >= 0 && cyc != last + 1)) begin
          tests_failed++;
          $display("FAIL bp_release[%0d]: got d=%h cyc=%0d expected d=%h cyc=%0d", got, d, cyc, exp[got], last + 1);
        end
        last = cyc;
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (got != 4) begin tests_failed++; $display("FAIL bp_count: got %0d expected 4", got); end
  endtask

  task automatic test_exhaustive();
    logic [OUT_W:0]   exp_q [$];
    logic [OUT_W:0]   e;
    logic [7:0]       p;
    bit               inf, ov, n, rdy;
    logic [OUT_W-1:0] d;
    int               sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 256 && cyc < 5000) begin
      p         = sent[7:0];
      in_posit  = p;
      in_valid  = (sent < 256);
      rdy       = ($urandom_range(0, 1) == 1);
      out_ready = rdy;
      tick(inf, ov, d, n);
      if (inf) begin
        exp_q.push_back({(p == 8'h80), ref_fixed(p)});
        sent++;
      end
      if (ov && rdy) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL exh_extra: got d=%h with empty scoreboard expected no output", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e[OUT_W-1:0] || n !== e[OUT_W]) begin
            tests_failed++;
            $display("FAIL exh_data[%0d]: got d=%h nar=%b expected d=%h nar=%b", got, d, n, e[OUT_W-1:0], e[OUT_W]);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (got != 256 || sent != 256) begin
      tests_failed++;
      $display("FAIL exh_count: got out=%0d in=%0d expected 256/256", got, sent);
    end
  endtask

  task automatic test_reset_midstream();
    bit               inf, ov, n;
    logic [OUT_W-1:0] d;
    int               acc;
    out_ready = 1'b0;
    cnt_clr   = 1'b1;
    tick(inf, ov, d, n);
    cnt_clr  = 1'b0;
    acc      = 0;
    in_posit = 8'h80;
    in_valid = 1'b1;
    for (int c = 0; c < 4 && acc < 2; c++) begin
      tick(inf, ov, d, n);
      if (inf) begin acc++; in_posit = 8'h50; end
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc != 2 || nar_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_setup: got acc=%0d count=%0d expected acc=2 count=1", acc, nar_count);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || nar_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got v=%b d=%h cnt=%0d expected v=0 d=0000 cnt=0", out_valid, out_data, nar_count);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    in_posit  = 8'hC0;
    in_valid  = 1'b1;
    tick(inf, ov, d, n);
    in_valid = 1'b0;
    tests_run++;
    if (!inf || ov) begin tests_failed++; $display("FAIL mid_accept: got accept=%b v=%b expected accept=1 v=0", inf, ov); end
    tick(inf, ov, d, n);
    tests_run++;
    if (ov) begin tests_failed++; $display("FAIL mid_stale: got v=1 d=%h expected v=0", d); end
    tick(inf, ov, d, n);
    tests_run++;
    if (!ov || d !== 16'hFF00) begin tests_failed++; $display("FAIL mid_after: got v=%b d=%h expected v=1 d=ff00", ov, d); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_nar();
    test_back_to_back();
    test_exhaustive();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
